// File: rtl/csr_trap_seq_if.sv
// CSR file access bus: one combinational read port and one write port.
// The sequencer drives the master side; the CSR file sits on the slave side.
interface csr_trap_seq_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 14
);
   logic [CSR_AW-1:0] csr_raddr;
   logic [XLEN-1:0]   csr_rdata;
   logic              csr_wr_en;
   logic [CSR_AW-1:0] csr_waddr;
   logic [XLEN-1:0]   csr_wdata;

   modport master (
      output csr_raddr,
      output csr_wr_en,
      output csr_waddr,
      output csr_wdata,
      input  csr_rdata
   );

   modport slave (
      input  csr_raddr,
      input  csr_wr_en,
      input  csr_waddr,
      input  csr_wdata,
      output csr_rdata
   );
endinterface

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer owning the CSR file write port; arbitrates pipeline CSR access
// against exception-entry and ERTN sequences. Define CSR_TRAP_BADV_EN to enable BADV writes.
module csr_trap_seq #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exc_valid_i,
   input  logic [5:0]        exc_ecode_i,
   input  logic [8:0]        exc_esubcode_i,
   input  logic [XLEN-1:0]   exc_pc_i,
   input  logic              exc_badv_valid_i,
   input  logic [XLEN-1:0]   exc_badv_i,
   input  logic              ertn_valid_i,
   output logic              trap_ready_o,
   input  logic              inst_csr_we_i,
   input  logic [CSR_AW-1:0] inst_csr_waddr_i,
   input  logic [XLEN-1:0]   inst_csr_wdata_i,
   input  logic [CSR_AW-1:0] inst_csr_raddr_i,
   output logic              inst_csr_ready_o,
   output logic [XLEN-1:0]   inst_csr_rdata_o,
   csr_trap_seq_if.master    csr,
   output logic              redirect_valid_o,
   output logic [XLEN-1:0]   redirect_pc_o
);

   // state     | meaning
   // IDLE      | pipeline access passes through; accepts exc/ertn
   // T_ERA..T_CRMD | exception entry: one CSR write per state
   // T_ENTRY   | read EENTRY, redirect fetch
   // R_PRMD/R_CRMD/R_ERA | ERTN: latch PRMD, restore CRMD, redirect to ERA
   typedef enum logic [3:0] {
      S_IDLE,
      S_T_ERA,
`ifdef CSR_TRAP_BADV_EN
      S_T_BADV,
`endif
      S_T_ESTAT,
      S_T_PRMD,
      S_T_CRMD,
      S_T_ENTRY,
      S_R_PRMD,
      S_R_CRMD,
      S_R_ERA
   } state_e;

   localparam logic [CSR_AW-1:0] A_CRMD   = CSR_AW'('h0);
   localparam logic [CSR_AW-1:0] A_PRMD   = CSR_AW'('h1);
   localparam logic [CSR_AW-1:0] A_ESTAT  = CSR_AW'('h5);
   localparam logic [CSR_AW-1:0] A_ERA    = CSR_AW'('h6);
   localparam logic [CSR_AW-1:0] A_EENTRY = CSR_AW'('hc);
`ifdef CSR_TRAP_BADV_EN
   localparam logic [CSR_AW-1:0] A_BADV   = CSR_AW'('h7);
`endif

   state_e            state_q, state_d;
   logic [5:0]        ecode_q, ecode_d;
   logic [8:0]        esub_q, esub_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   crmd_q, crmd_d;
   logic [2:0]        prmd_q, prmd_d;
`ifdef CSR_TRAP_BADV_EN
   logic [XLEN-1:0]   badv_q, badv_d;
   logic              badv_valid_q, badv_valid_d;
`else
   logic              unused_badv;
   assign unused_badv = ^{exc_badv_valid_i, exc_badv_i};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ecode_q      <= '0;
         esub_q       <= '0;
         pc_q         <= '0;
         crmd_q       <= '0;
         prmd_q       <= '0;
`ifdef CSR_TRAP_BADV_EN
         badv_q       <= '0;
         badv_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ecode_q      <= ecode_d;
         esub_q       <= esub_d;
         pc_q         <= pc_d;
         crmd_q       <= crmd_d;
         prmd_q       <= prmd_d;
`ifdef CSR_TRAP_BADV_EN
         badv_q       <= badv_d;
         badv_valid_q <= badv_valid_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      ecode_d          = ecode_q;
      esub_d           = esub_q;
      pc_d             = pc_q;
      crmd_d           = crmd_q;
      prmd_d           = prmd_q;
`ifdef CSR_TRAP_BADV_EN
      badv_d           = badv_q;
      badv_valid_d     = badv_valid_q;
`endif
      csr.csr_raddr    = inst_csr_raddr_i;
      csr.csr_wr_en    = 1'b0;
      csr.csr_waddr    = '0;
      csr.csr_wdata    = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;

      case (state_q)
         S_IDLE: begin
            if (exc_valid_i) begin
               ecode_d      = exc_ecode_i;
               esub_d       = exc_esubcode_i;
               pc_d         = exc_pc_i;
`ifdef CSR_TRAP_BADV_EN
               badv_d       = exc_badv_i;
               badv_valid_d = exc_badv_valid_i;
`endif
               state_d      = S_T_ERA;
            end else if (ertn_valid_i) begin
               state_d = S_R_PRMD;
            end else if (inst_csr_we_i) begin
               csr.csr_wr_en = 1'b1;
               csr.csr_waddr = inst_csr_waddr_i;
               csr.csr_wdata = inst_csr_wdata_i;
            end
         end
         S_T_ERA: begin
            csr.csr_raddr = A_CRMD;
            crmd_d        = csr.csr_rdata;
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_ERA;
            csr.csr_wdata = pc_q;
`ifdef CSR_TRAP_BADV_EN
            state_d       = badv_valid_q ? S_T_BADV : S_T_ESTAT;
         end
         S_T_BADV: begin
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_BADV;
            csr.csr_wdata = badv_q;
            state_d       = S_T_ESTAT;
`else
            state_d       = S_T_ESTAT;
`endif
         end
         S_T_ESTAT: begin
            // IS bits in the low half are owned by interrupt logic; write them back unchanged
            csr.csr_raddr = A_ESTAT;
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_ESTAT;
            csr.csr_wdata = {1'b0, esub_q, ecode_q, csr.csr_rdata[15:0]};
            state_d       = S_T_PRMD;
         end
         S_T_PRMD: begin
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_PRMD;
            csr.csr_wdata = {{(XLEN-3){1'b0}}, crmd_q[2:0]};
            state_d       = S_T_CRMD;
         end
         S_T_CRMD: begin
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_CRMD;
            csr.csr_wdata = {crmd_q[XLEN-1:3], 3'b000};
            state_d       = S_T_ENTRY;
         end
         S_T_ENTRY: begin
            csr.csr_raddr    = A_EENTRY;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = csr.csr_rdata;
            state_d          = S_IDLE;
         end
         S_R_PRMD: begin
            csr.csr_raddr = A_PRMD;
            prmd_d        = csr.csr_rdata[2:0];
            state_d       = S_R_CRMD;
         end
         S_R_CRMD: begin
            csr.csr_raddr = A_CRMD;
            csr.csr_wr_en = 1'b1;
            csr.csr_waddr = A_CRMD;
            csr.csr_wdata = {csr.csr_rdata[XLEN-1:3], prmd_q};
            state_d       = S_R_ERA;
         end
         S_R_ERA: begin
            csr.csr_raddr    = A_ERA;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = csr.csr_rdata;
            state_d          = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign trap_ready_o     = (state_q == S_IDLE);
   assign inst_csr_ready_o = (state_q == S_IDLE) && !exc_valid_i && !ertn_valid_i;
   assign inst_csr_rdata_o = csr.csr_rdata;

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Trap/return sequencer for the CSR file. Owns the CSR file's single write port and its read address, and arbitrates between pipeline `csrwr`/`csrxchg` writes and multi-cycle hardware update sequences. On an exception it sequences ERA/BADV/ESTAT/PRMD/CRMD updates and fetches EENTRY. On ERTN it restores CRMD from PRMD and fetches ERA. Sits between the commit stage and the CSR file; its redirect output feeds fetch.

## Interface
- `XLEN`, 32: CSR data / PC width; only 32 is supported.
- `CSR_AW`, 14: CSR address width.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `exc_valid`  in  1  exception request from commit
- `exc_ecode`  in  6  Ecode
- `exc_esubcode`  in  9  EsubCode
- `exc_pc`  in  32  faulting PC
- `exc_badv_valid`  in  1  BADV must be written
- `exc_badv`  in  32  faulting virtual address
- `ertn_valid`  in  1  ERTN request from commit
- `trap_ready`  out  1  sequencer idle; accepts exc/ertn
- `inst_csr_we`  in  1  pipeline CSR write request
- `inst_csr_waddr`  in  14  pipeline write address
- `inst_csr_wdata`  in  32  pipeline write data
- `inst_csr_raddr`  in  14  pipeline read address
- `inst_csr_ready`  out  1  pipeline CSR access granted this cycle
- `inst_csr_rdata`  out  32  read data to pipeline (`csr_rdata` passthrough)
- `csr_raddr`  out  14  to CSR file read port
- `csr_rdata`  in  32  from CSR file; combinational in `csr_raddr`
- `csr_wr_en`  out  1  to CSR file
- `csr_waddr`  out  14  to CSR file
- `csr_wdata`  out  32  to CSR file
- `redirect_valid`  out  1  one-cycle pulse; fetch redirect
- `redirect_pc`  out  32  redirect target

## Operation
- CSR addresses: CRMD 0x0, PRMD 0x1, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xc.
- States: IDLE, T_ERA, T_BADV, T_ESTAT, T_PRMD, T_CRMD, T_ENTRY, R_PRMD, R_CRMD, R_ERA.
- IDLE priority: `exc_valid` > `ertn_valid` > `inst_csr_we`.
  - Exc accepted: latch ecode, esubcode, pc, badv, badv_valid; go to T_ERA.
  - Else ERTN: go to R_PRMD.
  - Else pipeline access passes through combinationally: `csr_raddr=inst_csr_raddr`; `csr_wr_en/waddr/wdata = inst_csr_*`.
- `trap_ready` = (state==IDLE).
- `inst_csr_ready` = IDLE & !exc_valid & !ertn_valid. When not ready, `csr_wr_en` is never driven from `inst_csr_*`.
- Exception sequence:
  - T_ERA: read CRMD and latch it as `crmd_q`; write ERA=pc_q. Next state is T_BADV if badv_valid_q, else T_ESTAT.
  - T_BADV: write BADV=badv_q.
  - T_ESTAT: read ESTAT; write {1'b0, esub_q, ecode_q, rdata[15:0]}, preserving the IS bits.
  - T_PRMD: write {29'b0, crmd_q[2:0]} (PPLV, PIE).
  - T_CRMD: write {crmd_q[31:3], 3'b000} (PLV=0, IE=0).
  - T_ENTRY: read EENTRY; `redirect_valid=1`, `redirect_pc=csr_rdata`; go to IDLE.
- ERTN sequence:
  - R_PRMD: read PRMD and latch it as `prmd_q`.
  - R_CRMD: read CRMD; write {rdata[31:3], prmd_q[2:0]}.
  - R_ERA: read ERA; redirect to `csr_rdata`; go to IDLE.
- Outside IDLE, `exc_valid`/`ertn_valid`/`inst_csr_we` are ignored (not queued). Upstream holds requests until ready.
- `inst_csr_rdata` is always `csr_rdata`; it is valid only when `inst_csr_ready`.

## Timing
- Reset (synchronous): state=IDLE; `csr_wr_en=0`, `redirect_valid=0`, `redirect_pc=0`, `trap_ready=1`; all latches cleared.
- Reset asserted mid-sequence: next cycle is IDLE with no further writes. Partially written CSRs keep their values.
- Exc accepted in cycle N:
  - ERA write in N+1.
  - BADV write in N+2 if badv_valid_q.
  - ESTAT, PRMD, CRMD writes in the following consecutive cycles.
  - Redirect in N+6 with BADV, N+5 without.
- ERTN accepted in cycle N: CRMD write in N+2, redirect in N+3.
- Exactly one CSR write per cycle at most. Pipeline writes have zero added latency in IDLE.
- `trap_ready` rises in the cycle after the redirect. A new request can be accepted there, giving back-to-back traps with one idle cycle.

## Configuration
- `CSR_TRAP_BADV_EN` defined: T_BADV state present, behaviour as above.
- Undefined: T_BADV removed; `exc_badv_valid`/`exc_badv` ports remain but are ignored; BADV is never written; exception latency is fixed at 5 cycles.

## Test plan
- Reset then IDLE: `trap_ready=1`; write CSR 0x30 with 0xdeadbeef via `inst_csr_we` -> same-cycle `csr_wr_en=1`, `csr_waddr=0x30`, `inst_csr_ready=1`.
- Exc with ecode=0x8, esub=0, pc=0x1c000100, badv_valid=0, CRMD=0x0000000b, ESTAT=0x00000004, EENTRY=0x1c008000:
  - Writes: ERA=0x1c000100, ESTAT=0x00080004, PRMD=0x3, CRMD=0x8, in that order.
  - Redirect to 0x1c008000 at N+5.
- Exc with badv_valid=1, badv=0x80001234 -> BADV write in N+2; redirect at N+6 (BADV_EN defined). Same stimulus with BADV_EN undefined -> no BADV write; redirect at N+5.
- ERTN with PRMD=0x7, CRMD=0x8, ERA=0x1c000104:
  - CRMD write of 0xf at N+2.
  - Redirect to 0x1c000104 at N+3.
- `exc_valid`, `ertn_valid` and `inst_csr_we` asserted in the same cycle -> exception wins and `inst_csr_ready=0`. A pipeline write held during the sequence is granted only after return to IDLE.
- `reset` asserted in T_ESTAT -> no PRMD/CRMD writes, no redirect; `trap_ready=1` next cycle.
